rtc_set_ctrl: RTL and testbench
===============================

Name: rtc_set_ctrl

Overview:
- Run/set controller for the 24-hour BCD time-of-day counter.
- Generates the 1 Hz advance strobe from CLK with a prescaler.
- Sequences a button-driven set mode (hours -> minutes -> seconds) on a shadow copy of the time, then issues a one-cycle parallel load back to the counter.
- Sits between the front-panel button conditioner and the time counter; owns all writes to the time value.

Parameters:
- TICK_DIV, 50000000, CLK cycles per TICK. Minimum 2. Benches use 4.
- PRE_W, 26, prescaler width. Must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- RST  input  1  asynchronous reset, active-high
- CLK  input  1  clock, rising edge
- BTN_MODE  input  1  mode button; synchronous, already debounced, level
- BTN_INC  input  1  increment button; synchronous, already debounced, level
- CUR_HR  input  8  current hours from the counter, packed BCD 00..23
- CUR_MIN  input  8  current minutes, packed BCD 00..59
- CUR_SEC  input  8  current seconds, packed BCD 00..59
- TICK  output  1  one-cycle advance strobe to the counter
- LOAD  output  1  one-cycle parallel-load strobe
- SET_HR  output  8  shadow hours, BCD; valid whenever LOAD=1
- SET_MIN  output  8  shadow minutes, BCD
- SET_SEC  output  8  shadow seconds, BCD
- EDIT_SEL  output  3  field being edited: 0 none, 1 HR, 2 MIN, 3 SEC, 4 AL_HR, 5 AL_MIN
- RUN  output  1  high in state RUN only

Behaviour:
- Reset: state RUN.
- Reset values: TICK=0, LOAD=0, SET_*=8'h00, EDIT_SEL=0, RUN=1, prescaler=0.
- Reset values: both button history flops = 1, so a button held through reset produces no edge.
- Edge detect: rise = BTN & ~prev, where prev is the previous-cycle sample. An edge acts on the same CLK edge at which BTN is first sampled high.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only; TICK=1 in the cycle the count equals TICK_DIV-1, and the count returns to 0.
  - Frozen (holds value, TICK=0) in every edit state.
  - Cleared to 0 in COMMIT.
  - TICK is combinational from the count and state (zero latency).
- States and transitions:
  - RUN:
    - MODE rise -> EDIT_HR.
    - Same edge copies CUR_HR/CUR_MIN/CUR_SEC into the shadow registers.
    - INC ignored.
  - EDIT_HR (EDIT_SEL=1): INC rise increments SET_HR in BCD, 23 -> 00. MODE rise -> EDIT_MIN.
  - EDIT_MIN (EDIT_SEL=2): INC rise increments SET_MIN, 59 -> 00. MODE rise -> EDIT_SEC.
  - EDIT_SEC (EDIT_SEL=3):
    - INC rise increments SET_SEC, 59 -> 00.
    - MODE rise -> COMMIT, or -> EDIT_AHR when RTC_ALARM_EN is defined.
  - COMMIT (EDIT_SEL=0): LOAD=1 for exactly this cycle, prescaler cleared; unconditional -> RUN next cycle.
- BCD increment:
  - Low nibble 9 -> 0 with carry into the high nibble.
  - The wrap limit is compared on the full byte before incrementing.
  - Shadow values never leave their legal range.
- Simultaneous MODE and INC rises: MODE wins; the INC edge is discarded.
- LOAD is never asserted except in COMMIT. TICK and LOAD are never high together.
- Button edges arriving during COMMIT are discarded.
- First TICK after commit arrives TICK_DIV cycles after the LOAD cycle.
- Reset mid-edit: aborts to RUN with no LOAD; shadow values are cleared.

Optional Feature:
- Macro: RTC_ALARM_EN.
- When defined, add ports:
  - AL_ON  input  1  alarm enable
  - ALARM  output  1  registered alarm output, reset 0
- Adds alarm registers AL_HR/AL_MIN, reset 8'h00, which are not loaded into the counter.
- Adds edit states EDIT_AHR (EDIT_SEL=4, wrap 23) and EDIT_AMIN (EDIT_SEL=5, wrap 59).
- Sequence becomes EDIT_SEC -> EDIT_AHR -> EDIT_AMIN -> COMMIT on MODE rises.
- ALARM is registered each cycle to (RUN & AL_ON & CUR_HR==AL_HR & CUR_MIN==AL_MIN). It is therefore high for the whole matching minute and drops one cycle after entering an edit state.
- When undefined: no alarm ports, registers or states; EDIT_SEL values 4/5 never occur.

Test Plan:
- Prescaler (TICK_DIV=4, RST released, no buttons): TICK pulses on cycles 4, 8, 12 after release; RUN=1, LOAD=0 throughout.
- Enter edit and wrap hours:
  - CUR=12:34:56, MODE rise: EDIT_SEL=1, SET_*=12/34/56, TICK stops.
  - 12 INC rises: SET_HR=00 (wrap after 23).
- Full set and commit:
  - Starting in EDIT_HR at 00:34:56, apply MODE, 5 INC, MODE, 4 INC, MODE.
  - SET_MIN=39, SET_SEC=00 (59 wrapped after 56+4).
  - LOAD=1 for exactly one cycle with SET=00:39:00; next TICK 4 cycles later.
- Simultaneous MODE+INC in EDIT_MIN: state -> EDIT_SEC; SET_MIN unchanged.
- RST asserted in EDIT_SEC: immediately RUN=1, EDIT_SEL=0, SET_*=00, no LOAD pulse.
- Alarm (RTC_ALARM_EN defined):
  - Set alarm 07:30 with AL_ON=1; drive CUR=07:30:00 in RUN: ALARM=1 one cycle later.
  - CUR_MIN=31: ALARM=0 one cycle later.

Source files
------------

// File: rtl/rtc_set_ctrl.sv
// Run/set controller for the BCD time-of-day counter: 1 Hz prescaler plus button-driven edit/commit sequencing.
// Optional alarm registers, edit states and ALARM output are enabled with RTC_ALARM_EN.
module rtc_set_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic       RST,
  input  logic       CLK,
  input  logic       BTN_MODE,
  input  logic       BTN_INC,
  input  logic [7:0] CUR_HR,
  input  logic [7:0] CUR_MIN,
  input  logic [7:0] CUR_SEC,
`ifdef RTC_ALARM_EN
  input  logic       AL_ON,
  output logic       ALARM,
`endif
  output logic       TICK,
  output logic       LOAD,
  output logic [7:0] SET_HR,
  output logic [7:0] SET_MIN,
  output logic [7:0] SET_SEC,
  output logic [2:0] EDIT_SEL,
  output logic       RUN
);

  // state    | meaning
  // S_RUN    | prescaler counting, TICK strobes, waiting for MODE
  // S_HR     | editing shadow hours
  // S_MIN    | editing shadow minutes
  // S_SEC    | editing shadow seconds
  // S_AHR    | editing alarm hours (alarm build only)
  // S_AMIN   | editing alarm minutes (alarm build only)
  // S_COMMIT | one-cycle LOAD of the shadow time, prescaler cleared
  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_HR     = 3'd1,
    S_MIN    = 3'd2,
    S_SEC    = 3'd3,
`ifdef RTC_ALARM_EN
    S_AHR    = 3'd4,
    S_AMIN   = 3'd5,
`endif
    S_COMMIT = 3'd6
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic             mode_q, inc_q;
  logic             mode_rise, inc_rise;

`ifdef RTC_ALARM_EN
  logic [7:0] al_hr, al_min;
`endif

  assign mode_rise = BTN_MODE & ~mode_q;
  assign inc_rise  = BTN_INC & ~inc_q;
  assign TICK      = (state == S_RUN) && (pre == PRE_W'(TICK_DIV - 1));

  // Values at or above the limit wrap, so an out-of-range copy cannot escape the legal range.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim)
      return 8'h00;
    else if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return v + 8'h01;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_RUN;
      pre      <= '0;
      mode_q   <= 1'b1;
      inc_q    <= 1'b1;
      SET_HR   <= 8'h00;
      SET_MIN  <= 8'h00;
      SET_SEC  <= 8'h00;
      EDIT_SEL <= 3'd0;
      RUN      <= 1'b1;
      LOAD     <= 1'b0;
`ifdef RTC_ALARM_EN
      al_hr    <= 8'h00;
      al_min   <= 8'h00;
      ALARM    <= 1'b0;
`endif
    end else begin
      mode_q <= BTN_MODE;
      inc_q  <= BTN_INC;
`ifdef RTC_ALARM_EN
      ALARM  <= (state == S_RUN) && AL_ON && (CUR_HR == al_hr) && (CUR_MIN == al_min);
`endif
      case (state)
        S_RUN: begin
          pre <= TICK ? '0 : pre + PRE_W'(1);
          if (mode_rise) begin
            SET_HR   <= CUR_HR;
            SET_MIN  <= CUR_MIN;
            SET_SEC  <= CUR_SEC;
            state    <= S_HR;
            EDIT_SEL <= 3'd1;
            RUN      <= 1'b0;
          end
        end
        S_HR: begin
          if (mode_rise) begin
            state    <= S_MIN;
            EDIT_SEL <= 3'd2;
          end else if (inc_rise) begin
            SET_HR <= bcd_inc(SET_HR, 8'h23);
          end
        end
        S_MIN: begin
          if (mode_rise) begin
            state    <= S_SEC;
            EDIT_SEL <= 3'd3;
          end else if (inc_rise) begin
            SET_MIN <= bcd_inc(SET_MIN, 8'h59);
          end
        end
        S_SEC: begin
          if (mode_rise) begin
`ifdef RTC_ALARM_EN
            state    <= S_AHR;
            EDIT_SEL <= 3'd4;
`else
            state    <= S_COMMIT;
            EDIT_SEL <= 3'd0;
            LOAD     <= 1'b1;
`endif
          end else if (inc_rise) begin
            SET_SEC <= bcd_inc(SET_SEC, 8'h59);
          end
        end
`ifdef RTC_ALARM_EN
        S_AHR: begin
          if (mode_rise) begin
            state    <= S_AMIN;
            EDIT_SEL <= 3'd5;
          end else if (inc_rise) begin
            al_hr <= bcd_inc(al_hr, 8'h23);
          end
        end
        S_AMIN: begin
          if (mode_rise) begin
            state    <= S_COMMIT;
            EDIT_SEL <= 3'd0;
            LOAD     <= 1'b1;
          end else if (inc_rise) begin
            al_min <= bcd_inc(al_min, 8'h59);
          end
        end
`endif
        S_COMMIT: begin
          pre   <= '0;
          state <= S_RUN;
          LOAD  <= 1'b0;
          RUN   <= 1'b1;
        end
        default: begin
          state    <= S_RUN;
          EDIT_SEL <= 3'd0;
          LOAD     <= 1'b0;
          RUN      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Self-checking bench for rtc_set_ctrl with TICK_DIV=4; alarm scenario runs when RTC_ALARM_EN is defined.
module tb_rtc_set_ctrl;
  logic       RST, CLK, BTN_MODE, BTN_INC;
  logic [7:0] CUR_HR, CUR_MIN, CUR_SEC;
  logic       TICK, LOAD, RUN;
  logic [7:0] SET_HR, SET_MIN, SET_SEC;
  logic [2:0] EDIT_SEL;
`ifdef RTC_ALARM_EN
  logic       AL_ON, ALARM;
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // model: 0 RUN, 1 HR, 2 MIN, 3 SEC, 4 AHR, 5 AMIN, 6 COMMIT
  int         mst;
  logic [7:0] mh, mm, ms;
  logic [27:0] sb[$];
  logic [27:0] got, exp_v;

  rtc_set_ctrl #(.TICK_DIV(4), .PRE_W(3)) dut (
    .RST(RST), .CLK(CLK), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
    .CUR_HR(CUR_HR), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
`ifdef RTC_ALARM_EN
    .AL_ON(AL_ON), .ALARM(ALARM),
`endif
    .TICK(TICK), .LOAD(LOAD), .SET_HR(SET_HR), .SET_MIN(SET_MIN),
    .SET_SEC(SET_SEC), .EDIT_SEL(EDIT_SEL), .RUN(RUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] binc(input logic [7:0] v, input int lim);
    int b;
    logic [3:0] t, u;
    b = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % (lim + 1);
    t = 4'(b / 10);
    u = 4'(b % 10);
    return {t, u};
  endfunction

  // Apply one button sample, advance the model, push the expected outputs.
  task automatic drive(input logic m, input logic i);
    logic [2:0] sel;
    if (m) begin
      case (mst)
        0: begin mh = CUR_HR; mm = CUR_MIN; ms = CUR_SEC; mst = 1; end
        1: mst = 2;
        2: mst = 3;
        3: mst = ALM ? 4 : 6;
        4: mst = 5;
        5: mst = 6;
        default: ;
      endcase
    end else if (i) begin
      case (mst)
        1: mh = binc(mh, 23);
        2: mm = binc(mm, 59);
        3: ms = binc(ms, 59);
        default: ;
      endcase
    end
    sel = (mst == 6) ? 3'd0 : 3'(mst);
    sb.push_back({sel, mh, mm, ms, (mst == 6)});
    BTN_MODE = m;
    BTN_INC  = i;
    @(posedge CLK); #1;
  endtask

  task automatic release_btn;
    BTN_MODE = 1'b0;
    BTN_INC  = 1'b0;
    @(posedge CLK); #1;
    if (mst == 6) mst = 0;
  endtask

  task automatic test_reset;
    RST = 1'b1; BTN_MODE = 1'b0; BTN_INC = 1'b0;
    CUR_HR = 8'h00; CUR_MIN = 8'h00; CUR_SEC = 8'h00;
`ifdef RTC_ALARM_EN
    AL_ON = 1'b0;
`endif
    mst = 0; mh = 8'h00; mm = 8'h00; ms = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({RUN, TICK, LOAD, EDIT_SEL, SET_HR, SET_MIN, SET_SEC} !== {1'b1, 1'b0, 1'b0, 3'd0, 24'h0}) begin
      errors++;
      $display("FAIL reset_state got run=%b tick=%b load=%b sel=%0d set=%h:%h:%h want 1 0 0 0 00:00:00",
               RUN, TICK, LOAD, EDIT_SEL, SET_HR, SET_MIN, SET_SEC);
    end
`ifdef RTC_ALARM_EN
    checks++;
    if (ALARM !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b want 0", ALARM); end
`endif
    RST = 1'b0;
  endtask

  task automatic test_prescaler;
    for (int n = 1; n <= 12; n++) begin
      @(posedge CLK); #1;
      checks++;
      if ({TICK, RUN, LOAD} !== {(n % 4 == 3), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL prescaler cycle %0d got tick=%b run=%b load=%b want tick=%b run=1 load=0",
                 n, TICK, RUN, LOAD, (n % 4 == 3));
      end
    end
  endtask

  task automatic test_enter_edit;
    CUR_HR = 8'h12; CUR_MIN = 8'h34; CUR_SEC = 8'h56;
    drive(1'b1, 1'b0);
    exp_v = sb.pop_front(); got = {EDIT_SEL, SET_HR, SET_MIN, SET_SEC, LOAD};
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL enter_edit got %h want %h", got, exp_v); end
    release_btn();
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (TICK !== 1'b0) begin errors++; $display("FAIL tick_frozen cycle %0d got %b want 0", k, TICK); end
    end
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b1);
      exp_v = sb.pop_front(); got = {EDIT_SEL, SET_HR, SET_MIN, SET_SEC, LOAD};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL hr_inc step %0d got %h want %h", k, got, exp_v); end
      release_btn();
    end
    checks++;
    if (SET_HR !== 8'h00) begin errors++; $display("FAIL hr_wrap got %h want 00", SET_HR); end
  endtask

  task automatic test_full_commit;
    logic [1:0] seq[$];
    seq = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    if (ALM) begin seq.push_back(2'b10); seq.push_back(2'b10); end
    foreach (seq[k]) begin
      drive(seq[k][1], seq[k][0]);
      exp_v = sb.pop_front(); got = {EDIT_SEL, SET_HR, SET_MIN, SET_SEC, LOAD};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL commit_seq step %0d got %h want %h", k, got, exp_v); end
      if (k != seq.size() - 1) release_btn();
    end
    checks++;
    if ({LOAD, TICK, SET_HR, SET_MIN, SET_SEC} !== {1'b1, 1'b0, 24'h003900}) begin
      errors++;
      $display("FAIL load_pulse got load=%b tick=%b set=%h:%h:%h want 1 0 00:39:00",
               LOAD, TICK, SET_HR, SET_MIN, SET_SEC);
    end
    release_btn();
    checks++;
    if ({LOAD, RUN, TICK} !== 3'b010) begin
      errors++; $display("FAIL after_load got load=%b run=%b tick=%b want 0 1 0", LOAD, RUN, TICK);
    end
    for (int k = 2; k <= 4; k++) begin
      @(posedge CLK); #1;
      checks++;
      if ({TICK, LOAD} !== {(k == 4), 1'b0}) begin
        errors++; $display("FAIL tick_after_commit cycle %0d got tick=%b load=%b want %b 0", k, TICK, LOAD, (k == 4));
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [1:0] seq[$];
    CUR_HR = 8'h09; CUR_MIN = 8'h59; CUR_SEC = 8'h08;
    seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b01};
    foreach (seq[k]) begin
      drive(seq[k][1], seq[k][0]);
      exp_v = sb.pop_front(); got = {EDIT_SEL, SET_HR, SET_MIN, SET_SEC, LOAD};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL simul step %0d got %h want %h", k, got, exp_v); end
      release_btn();
    end
    checks++;
    if ({EDIT_SEL, SET_HR, SET_MIN, SET_SEC} !== {3'd3, 24'h100009}) begin
      errors++; $display("FAIL simul_final got sel=%0d set=%h:%h:%h want 3 10:00:09", EDIT_SEL, SET_HR, SET_MIN, SET_SEC);
    end
  endtask

  task automatic test_reset_mid_edit;
    BTN_MODE = 1'b1;
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({RUN, EDIT_SEL, LOAD, SET_HR, SET_MIN, SET_SEC} !== {1'b1, 3'd0, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL reset_mid_edit got run=%b sel=%0d load=%b set=%h:%h:%h want 1 0 0 00:00:00",
               RUN, EDIT_SEL, LOAD, SET_HR, SET_MIN, SET_SEC);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (LOAD !== 1'b0) begin errors++; $display("FAIL load_in_reset got %b want 0", LOAD); end
    end
    RST = 1'b0;
    mst = 0; mh = 8'h00; mm = 8'h00; ms = 8'h00;
    sb.delete();
    @(posedge CLK); #1;
    checks++;
    if ({RUN, EDIT_SEL} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL held_button_no_edge got run=%b sel=%0d want 1 0", RUN, EDIT_SEL);
    end
    BTN_MODE = 1'b0;
    @(posedge CLK); #1;
  endtask

`ifdef RTC_ALARM_EN
  task automatic test_alarm;
    logic [1:0] seq[$];
    CUR_HR = 8'h12; CUR_MIN = 8'h34; CUR_SEC = 8'h56;
    AL_ON = 1'b1;
    seq = '{2'b10, 2'b10, 2'b10, 2'b10};
    repeat (7) seq.push_back(2'b01);
    seq.push_back(2'b10);
    repeat (30) seq.push_back(2'b01);
    seq.push_back(2'b10);
    foreach (seq[k]) begin
      drive(seq[k][1], seq[k][0]);
      exp_v = sb.pop_front(); got = {EDIT_SEL, SET_HR, SET_MIN, SET_SEC, LOAD};
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL alarm_seq step %0d got %h want %h", k, got, exp_v); end
      release_btn();
    end
    checks++;
    if (ALARM !== 1'b0) begin errors++; $display("FAIL alarm_nomatch got %b want 0", ALARM); end
    CUR_HR = 8'h07; CUR_MIN = 8'h30; CUR_SEC = 8'h00;
    @(posedge CLK); #1;
    checks++;
    if (ALARM !== 1'b1) begin errors++; $display("FAIL alarm_match got %b want 1", ALARM); end
    CUR_MIN = 8'h31;
    @(posedge CLK); #1;
    checks++;
    if (ALARM !== 1'b0) begin errors++; $display("FAIL alarm_drop got %b want 0", ALARM); end
  endtask
`endif

  initial begin
    test_reset();
    test_prescaler();
    test_enter_edit();
    test_full_commit();
    test_simultaneous();
    test_reset_mid_edit();
`ifdef RTC_ALARM_EN
    test_alarm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
